// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if;

  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic        MemReqM;
  logic        MemReadyM;
  logic [4:0]  RdW;
  logic        RegWriteW;

  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        StallM;
  logic        FlushD;
  logic        FlushE;
  logic        FlushW;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic        MemErr;
  logic [31:0] StallCount;
  logic [31:0] FlushCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, RdM, RegWriteM,
           MemReqM, MemReadyM, RdW, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE,
           ForwardBE, MemErr, StallCount, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, RdM, RegWriteM,
           MemReqM, MemReadyM, RdW, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE,
           ForwardBE, MemErr, StallCount, FlushCount
  );

endinterface

// File: rtl/forward_unit.sv
// Operand bypass select for one ALU input; MEM result beats WB, x0 never forwarded.
import hazard_pkg::*;

module forward_unit (
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output fwd_sel_t   fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
      fwd_o = FWD_MEM;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control with a timed data-memory wait FSM.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
import hazard_pkg::*;

module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  localparam logic [7:0] TimeoutCnt = MEM_TIMEOUT[7:0];

  mem_state_t state_q;
  logic [7:0] wait_cnt_q;
  logic       mem_err_q;
  logic       lw_stall;
  logic       timeout_hit;
  logic       mem_wait;
  fwd_sel_t   fwd_a;
  fwd_sel_t   fwd_b;

  forward_unit u_fwd_a (
    .rs_e_i        (hz.Rs1E),
    .rd_m_i        (hz.RdM),
    .reg_write_m_i (hz.RegWriteM),
    .rd_w_i        (hz.RdW),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs_e_i        (hz.Rs2E),
    .rd_m_i        (hz.RdM),
    .reg_write_m_i (hz.RegWriteM),
    .rd_w_i        (hz.RdW),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (fwd_b)
  );

  always_comb begin
    lw_stall    = (hz.ResultSrcE == RESULT_SRC_LOAD) && (hz.RdE != 5'd0) &&
                  ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    // Ready in the timeout cycle counts as normal completion.
    timeout_hit = (state_q == WAIT) && !hz.MemReadyM && (wait_cnt_q == TimeoutCnt);
    mem_wait    = hz.MemReqM && !hz.MemReadyM && !timeout_hit;
  end

  always_comb begin
    hz.ForwardAE = fwd_a;
    hz.ForwardBE = fwd_b;
    hz.MemErr    = mem_err_q;
    if (mem_wait) begin
      // EX is frozen, so load-use and branch redirects wait for release.
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushD = 1'b0;
      hz.FlushE = 1'b0;
      hz.FlushW = 1'b1;
    end else begin
      hz.StallF = lw_stall;
      hz.StallD = lw_stall;
      hz.StallE = 1'b0;
      hz.StallM = 1'b0;
      hz.FlushD = hz.PCSrcE;
      hz.FlushE = lw_stall || hz.PCSrcE;
      hz.FlushW = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
    end else begin
      mem_err_q <= timeout_hit;
      case (state_q)
        IDLE: begin
          if (mem_wait) begin
            state_q    <= WAIT;
            wait_cnt_q <= 8'd1;
          end
        end
        WAIT: begin
          if (hz.MemReadyM || timeout_hit) begin
            state_q    <= IDLE;
            wait_cnt_q <= 8'd0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wait_cnt_q <= 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (hz.StallF && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (hz.FlushE && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;
`else
  assign hz.StallCount = 32'h0;
  assign hz.FlushCount = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: cycles spent on the current access (0 = none outstanding).
  int     waited    = 0;
  bit     err_q     = 1'b0;
  longint stall_cnt = 0;
  longint flush_cnt = 0;
  bit     m_tout, m_wait, m_lw;
  bit     e_stf, e_fe;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] fwd_ref(logic [4:0] rs, logic [4:0] rdm, logic wm,
                                         logic [4:0] rdw, logic ww);
    if (wm && rdm != 0 && rdm == rs) return 2'b10;
    if (ww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_in();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
    hz.ResultSrcE = 0; hz.PCSrcE = 0; hz.RdM = 0; hz.RegWriteM = 0;
    hz.MemReqM = 0; hz.MemReadyM = 0; hz.RdW = 0; hz.RegWriteW = 0;
  endtask

  // Check every output against the model at the falling edge.
  task automatic sample();
    logic [31:0] e_sc, e_fc;
    @(negedge clk);
    if (!rst_n) begin
      waited = 0; err_q = 0; stall_cnt = 0; flush_cnt = 0;
    end
    m_lw   = (hz.ResultSrcE == 2'b01) && (hz.RdE != 0) &&
             ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    m_tout = (waited == int'(TO)) && !hz.MemReadyM;
    m_wait = hz.MemReqM && !hz.MemReadyM && !m_tout;
    e_stf  = m_wait || m_lw;
    e_fe   = !m_wait && (m_lw || hz.PCSrcE);
`ifdef HAZARD_PERF_EN
    e_sc = stall_cnt[31:0];
    e_fc = flush_cnt[31:0];
`else
    e_sc = 32'd0;
    e_fc = 32'd0;
`endif
    chk("StallF", 32'(hz.StallF), 32'(e_stf));
    chk("StallD", 32'(hz.StallD), 32'(e_stf));
    chk("StallE", 32'(hz.StallE), 32'(m_wait));
    chk("StallM", 32'(hz.StallM), 32'(m_wait));
    chk("FlushD", 32'(hz.FlushD), 32'(!m_wait && hz.PCSrcE));
    chk("FlushE", 32'(hz.FlushE), 32'(e_fe));
    chk("FlushW", 32'(hz.FlushW), 32'(m_wait));
    chk("ForwardAE", 32'(hz.ForwardAE),
        32'(fwd_ref(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW)));
    chk("ForwardBE", 32'(hz.ForwardBE),
        32'(fwd_ref(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW)));
    chk("MemErr", 32'(hz.MemErr), 32'(err_q));
    chk("StallCount", hz.StallCount, e_sc);
    chk("FlushCount", hz.FlushCount, e_fc);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      err_q = m_tout;
      if (e_stf && stall_cnt < 64'hFFFF_FFFF) stall_cnt++;
      if (e_fe && flush_cnt < 64'hFFFF_FFFF) flush_cnt++;
      if (waited == 0) waited = m_wait ? 1 : 0;
      else if (hz.MemReadyM || m_tout) waited = 0;
      else waited++;
    end
    #1;
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    sample();
    chk("reset_memerr", 32'(hz.MemErr), 32'd0);
    advance();
    rst_n = 1'b1;

    // Forwarding: MEM beats WB, then x0 in MEM falls back to WB.
    hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1;
    sample();
    chk("fwdA_mem", 32'(hz.ForwardAE), 32'd2);
    advance();
    hz.RdM = 0;
    sample();
    chk("fwdA_wb", 32'(hz.ForwardAE), 32'd1);
    advance();
    clear_in();

    // Load-use: one stall cycle then clear.
    hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7;
    sample();
    chk("lw_stallF", 32'(hz.StallF), 32'd1);
    chk("lw_flushE", 32'(hz.FlushE), 32'd1);
    advance();
    clear_in();
    sample();
    chk("lw_release", 32'(hz.StallF), 32'd0);
    advance();

    // Taken branch.
    hz.PCSrcE = 1;
    sample();
    chk("br_flushD", 32'(hz.FlushD), 32'd1);
    advance();
    clear_in();

    // Load-use and branch together.
    hz.ResultSrcE = 2'b01; hz.RdE = 3; hz.Rs1D = 3; hz.PCSrcE = 1;
    sample();
    advance();
    clear_in();

    // Access completes after 3 stalled cycles.
    hz.MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("mem3_stallM", 32'(hz.StallM), 32'd1);
      advance();
    end
    hz.MemReadyM = 1;
    sample();
    chk("mem3_done", 32'(hz.StallM), 32'd0);
    advance();
    clear_in();
    sample();
    chk("mem3_noerr", 32'(hz.MemErr), 32'd0);
    advance();

    // Zero-stall access.
    hz.MemReqM = 1; hz.MemReadyM = 1;
    sample();
    chk("mem0_nostall", 32'(hz.StallM), 32'd0);
    advance();
    clear_in();

    // Timeout: TO stalls, a release cycle, then a one-cycle error pulse.
    hz.MemReqM = 1;
    for (int i = 0; i < int'(TO); i++) begin
      sample();
      chk("to_stall", 32'(hz.StallM), 32'd1);
      advance();
    end
    sample();
    chk("to_release", 32'(hz.StallM), 32'd0);
    advance();
    clear_in();
    sample();
    chk("to_memerr", 32'(hz.MemErr), 32'd1);
    advance();
    sample();
    chk("to_memerr_clr", 32'(hz.MemErr), 32'd0);
    advance();

    // Ready arriving in the timeout cycle wins.
    hz.MemReqM = 1;
    for (int i = 0; i < int'(TO); i++) begin
      sample();
      advance();
    end
    hz.MemReadyM = 1;
    sample();
    advance();
    clear_in();
    sample();
    chk("to_ready_noerr", 32'(hz.MemErr), 32'd0);
    advance();

    // Reset during the second wait cycle.
    hz.MemReqM = 1;
    for (int i = 0; i < 2; i++) begin
      sample();
      advance();
    end
    rst_n = 1'b0;
    sample();
    chk("rst_memerr", 32'(hz.MemErr), 32'd0);
    chk("rst_stallcnt", hz.StallCount, 32'd0);
    advance();
    hz.MemReqM = 0;
    rst_n = 1'b1;
    for (int i = 0; i < int'(TO) + 2; i++) begin
      sample();
      advance();
    end

    // Randomized traffic; keep the request held while an access is outstanding.
    for (int i = 0; i < 400; i++) begin
      hz.Rs1D = 5'($urandom_range(0, 3));
      hz.Rs2D = 5'($urandom_range(0, 3));
      hz.Rs1E = 5'($urandom_range(0, 3));
      hz.Rs2E = 5'($urandom_range(0, 3));
      hz.RdE  = 5'($urandom_range(0, 3));
      hz.RdM  = 5'($urandom_range(0, 3));
      hz.RdW  = 5'($urandom_range(0, 3));
      hz.ResultSrcE = 2'($urandom_range(0, 3));
      hz.PCSrcE    = ($urandom_range(0, 3) == 0);
      hz.RegWriteM = 1'($urandom);
      hz.RegWriteW = 1'($urandom);
      hz.MemReqM   = (waited > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      hz.MemReadyM = ($urandom_range(0, 5) == 0);
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
